dmi_initiator: RTL
==================

DMI_INITIATOR -- requirements
Module: dmi_initiator

Interface
REQ-001 Parameter: ADDR_BITS, 7, DMI address width.
REQ-002 Parameter: TIMEOUT, 1023, maximum cycles to wait for a DMI response after the request handshake.
REQ-003 Port: clock  in  1  sole clock; one clock, all logic on its rising edge.
REQ-004 Port: reset  in  1  synchronous, active-high reset.
REQ-005 Port: cmd_valid/cmd_ready  in/out  1/1  host command handshake.
REQ-006 Port: cmd_op  in  2  0=NOP, 1=READ, 2=WRITE, 3=reserved (treated as NOP).
REQ-007 Port: cmd_addr  in  ADDR_BITS  DMI register address.
REQ-008 Port: cmd_data  in  32  write data.
REQ-009 Port: rsp_valid/rsp_ready  out/in  1/1  host result handshake.
REQ-010 Port: rsp_data  out  32  read data, or last captured data.
REQ-011 Port: rsp_status  out  2  0=ok, 2=failed, 3=busy.
REQ-012 Port: dmi_req_valid/dmi_req_ready  out/in  1/1  DMI request handshake to the debug module.
REQ-013 Port: dmi_req_addr, dmi_req_data, dmi_req_op  out  ADDR_BITS, 32, 2  DMI request fields.
REQ-014 Port: dmi_resp_valid/dmi_resp_ready  in/out  1/1  DMI response handshake.
REQ-015 Port: dmi_resp_data, dmi_resp_code  in  32, 2  DMI response fields.
REQ-016 Port: dmireset  in  1  single-cycle pulse that clears the sticky error.
REQ-017 Port: sticky_err  out  2  current sticky status; busy  out  1  high whenever state is not IDLE.

Function
REQ-018 FSM states: IDLE, REQ, WAIT, DRAIN, RESP.
REQ-019 cmd_ready is high only in IDLE with rsp_valid low.
REQ-020 In IDLE, a cmd fire with op READ/WRITE and sticky_err==0 latches the fields and enters REQ; dmi_req_valid rises on the next cycle.
REQ-021 A cmd fire with NOP/reserved op, or with sticky_err!=0, issues no DMI request: RESP next cycle, rsp_status=sticky_err, rsp_data=last captured data.
REQ-022 In REQ, dmi_req_valid and its fields are held stable until dmi_req_ready; on that fire go to WAIT, clear the timeout counter.
REQ-023 In WAIT, dmi_resp_ready=1; on fire, capture dmi_resp_data (READ only; WRITE leaves it unchanged) and go to RESP with rsp_status=dmi_resp_code.
REQ-024 Response code 2 or 3 is copied into sticky_err; codes 0 and 1 leave it unchanged, and code 1 is reported to host as 2.
REQ-025 Timeout counter increments each WAIT cycle; at TIMEOUT without a response: sticky_err=3, rsp_status=3, enter DRAIN.
REQ-026 In DRAIN, dmi_resp_ready=1; the late response is discarded without updating data or sticky; then enter RESP. A response arriving in the same cycle as the timeout is accepted normally and counts as no timeout.
REQ-027 In RESP, rsp_valid is held with stable data/status until rsp_ready, then return to IDLE; minimum command-to-result latency is 3 cycles after cmd fire with a zero-wait responder.
REQ-028 dmireset clears sticky_err in any state; if it coincides with a sticky update, the update wins; if it coincides with a cmd fire, the clear applies before the sticky check.
REQ-029 dmi_resp_ready is 0 outside WAIT/DRAIN; responses outside those states are not consumed.

Reset
REQ-030 Reset forces IDLE; sticky_err, captured data, counter, rsp_valid, dmi_req_valid, dmi_resp_ready and busy are 0; cmd_ready is 1 on the first cycle after reset.
REQ-031 Reset mid-transaction abandons it silently; no host result is produced for it.

Structure
REQ-032 Shared package dmi_pkg holds the op encodings (NOP/READ/WRITE), response codes (OK/FAILED/BUSY) and the FSM state enum.
REQ-033 Single flat module; no sub-module is required.

Verification
REQ-034 READ addr 0x11, responder returns data 0x0000_0C82 code 0 after 2 cycles -> rsp_data 0x0000_0C82, status 0, single dmi_req fire.
REQ-035 WRITE addr 0x10 data 0x8000_0001, responder code 2 -> rsp_status 2, sticky_err 2; next READ issues no DMI request and returns status 2.
REQ-036 Responder silent with TIMEOUT=15 -> status 3 at cycle 15 of WAIT, sticky 3; response delivered later is drained and the next command is blocked until drained.
REQ-037 dmireset pulsed with cmd fire while sticky=3 -> command issued to DMI, status 0.
REQ-038 dmi_req_ready held low 10 cycles plus rsp_ready low 5 cycles -> request fields and rsp outputs remain stable throughout; reset asserted in WAIT -> IDLE with no rsp_valid.

Source files
------------

// File: rtl/dmi_pkg.sv
// DMI initiator shared definitions: op encodings, response codes,
// FSM states and the response-code to host-status mapping.
package dmi_pkg;

  typedef enum logic [1:0] {
    OP_NOP   = 2'd0,
    OP_READ  = 2'd1,
    OP_WRITE = 2'd2
  } dmi_op_e;

  typedef enum logic [1:0] {
    RSP_OK     = 2'd0,
    RSP_FAILED = 2'd2,
    RSP_BUSY   = 2'd3
  } dmi_rsp_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DRAIN,
    S_RESP
  } dmi_state_e;

  // Code 1 is reserved on the DMI side; the host only sees ok/failed/busy.
  function automatic logic [1:0] host_status(input logic [1:0] code);
    return (code == 2'd1) ? RSP_FAILED : code;
  endfunction

  // Failed and busy are the codes that stick until dmireset.
  function automatic logic is_sticky(input logic [1:0] code);
    return code[1];
  endfunction

endpackage

// File: rtl/dmi_initiator.sv
// DMI initiator: turns host commands into DMI request/response transactions.
// Ports: clock/reset; cmd_* host command in; rsp_* host result out;
// dmi_req_* / dmi_resp_* DMI side; dmireset clears sticky_err; busy when not IDLE.
module dmi_initiator
  import dmi_pkg::*;
#(
  parameter int ADDR_BITS = 7,
  parameter int TIMEOUT   = 1023
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [1:0]           cmd_op,
  input  logic [ADDR_BITS-1:0] cmd_addr,
  input  logic [31:0]          cmd_data,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [31:0]          rsp_data,
  output logic [1:0]           rsp_status,
  output logic                 dmi_req_valid,
  input  logic                 dmi_req_ready,
  output logic [ADDR_BITS-1:0] dmi_req_addr,
  output logic [31:0]          dmi_req_data,
  output logic [1:0]           dmi_req_op,
  input  logic                 dmi_resp_valid,
  output logic                 dmi_resp_ready,
  input  logic [31:0]          dmi_resp_data,
  input  logic [1:0]           dmi_resp_code,
  input  logic                 dmireset,
  output logic [1:0]           sticky_err,
  output logic                 busy
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  dmi_state_e           state_q;
  logic                 cmd_ready_q;
  logic                 rsp_valid_q;
  logic [1:0]           rsp_status_q;
  logic [31:0]          data_q;
  logic [1:0]           sticky_q;
  logic                 req_valid_q;
  logic                 resp_ready_q;
  logic                 busy_q;
  logic [CW-1:0]        cnt_q;
  logic [1:0]           op_q;
  logic [ADDR_BITS-1:0] addr_q;
  logic [31:0]          wdata_q;

  logic       cmd_fire;
  logic       cmd_rw;
  logic [1:0] sticky_d;

  assign cmd_fire = cmd_valid & cmd_ready_q;
  assign cmd_rw   = (cmd_op == OP_READ) | (cmd_op == OP_WRITE);
  // A dmireset in the fire cycle clears before the sticky check.
  assign sticky_d = dmireset ? 2'd0 : sticky_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cmd_ready_q  <= 1'b1;
      rsp_valid_q  <= 1'b0;
      rsp_status_q <= RSP_OK;
      data_q       <= '0;
      sticky_q     <= '0;
      req_valid_q  <= 1'b0;
      resp_ready_q <= 1'b0;
      busy_q       <= 1'b0;
      cnt_q        <= '0;
      op_q         <= OP_NOP;
      addr_q       <= '0;
      wdata_q      <= '0;
    end else begin
      // Later sticky updates in the case below override this clear.
      if (dmireset) sticky_q <= '0;
      unique case (state_q)
        S_IDLE: begin
          if (cmd_fire) begin
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            if (cmd_rw && sticky_d == 2'd0) begin
              op_q        <= cmd_op;
              addr_q      <= cmd_addr;
              wdata_q     <= cmd_data;
              req_valid_q <= 1'b1;
              state_q     <= S_REQ;
            end else begin
              rsp_status_q <= sticky_d;
              rsp_valid_q  <= 1'b1;
              state_q      <= S_RESP;
            end
          end
        end
        S_REQ: begin
          if (dmi_req_ready) begin
            req_valid_q  <= 1'b0;
            resp_ready_q <= 1'b1;
            cnt_q        <= '0;
            state_q      <= S_WAIT;
          end
        end
        S_WAIT: begin
          // A response on the last counted cycle still wins.
          if (dmi_resp_valid) begin
            if (op_q == OP_READ) data_q <= dmi_resp_data;
            if (is_sticky(dmi_resp_code)) sticky_q <= dmi_resp_code;
            rsp_status_q <= host_status(dmi_resp_code);
            resp_ready_q <= 1'b0;
            rsp_valid_q  <= 1'b1;
            state_q      <= S_RESP;
          end else if (cnt_q == LAST) begin
            sticky_q     <= RSP_BUSY;
            rsp_status_q <= RSP_BUSY;
            state_q      <= S_DRAIN;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_DRAIN: begin
          // Late response is swallowed; data and sticky are untouched.
          if (dmi_resp_valid) begin
            resp_ready_q <= 1'b0;
            rsp_valid_q  <= 1'b1;
            state_q      <= S_RESP;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          state_q      <= S_IDLE;
          cmd_ready_q  <= 1'b1;
          rsp_valid_q  <= 1'b0;
          req_valid_q  <= 1'b0;
          resp_ready_q <= 1'b0;
          busy_q       <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready      = cmd_ready_q;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_data       = data_q;
  assign rsp_status     = rsp_status_q;
  assign dmi_req_valid  = req_valid_q;
  assign dmi_req_addr   = addr_q;
  assign dmi_req_data   = wdata_q;
  assign dmi_req_op     = op_q;
  assign dmi_resp_ready = resp_ready_q;
  assign sticky_err     = sticky_q;
  assign busy           = busy_q;

endmodule
